// File: rtl/ff_ga_stack_pkg.sv
// Shared encodings and helpers for the fixed-point geometry accelerator.
// The matrix type macro lets each module size the 4x4 word array to its own DATA_W.
`define FF_GA_MAT4_T(W) logic signed [0:3][0:3][(W)-1:0]

package ff_ga_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        MATRIX = 3'd0,
        VRT    = 3'd1,
        RSLT   = 3'd2,
        IDENT  = 3'd3,
        PUSH   = 3'd4,
        POP    = 3'd5
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MUL,
        READ,
        STK
    } state_e;

    typedef `FF_GA_MAT4_T(DEF_DATA_W) mat4_t;

    // Identity element at (r,c) for a Q(.frac_w) format; callers truncate to their width.
    function automatic logic [63:0] ident_word(input int r, input int c, input int frac_w);
        return (r == c) ? (64'd1 << frac_w) : 64'd0;
    endfunction

endpackage

// File: rtl/ff_ga_stack_if.sv
// Command/data bus of the geometry accelerator: host drives command and rows,
// the accelerator returns result columns, ready and stack status.
interface ff_ga_stack_if #(
    parameter int DATA_W      = 32,
    parameter int STACK_DEPTH = 8
);
    localparam int LW = $clog2(STACK_DEPTH + 1);

    logic [31:0]            addr;
    logic [0:3][DATA_W-1:0] data_in;
    logic [0:3][DATA_W-1:0] data_out;
    logic                   rdy;
    logic                   err_ovf;
    logic                   err_udf;
    logic [LW-1:0]          stack_lvl;

    modport master (
        output addr, data_in,
        input  data_out, rdy, err_ovf, err_udf, stack_lvl
    );

    modport slave (
        input  addr, data_in,
        output data_out, rdy, err_ovf, err_udf, stack_lvl
    );
endinterface

// File: rtl/ff_ga_row_mac.sv
// One composite row times a full 4x4 operand: four full-precision dot products,
// each shifted down by FRAC_W (floor) and saturated to DATA_W.
module ff_ga_row_mac #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic [0:3][DATA_W-1:0]      row_i,
    input  logic [0:3][0:3][DATA_W-1:0] mat_i,
    output logic [0:3][DATA_W-1:0]      res_o
);
    localparam int SW = 2 * DATA_W + 2;
    localparam logic signed [SW-1:0] MAX_V = {{(SW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = ~MAX_V;

    function automatic logic signed [SW-1:0] sext(input logic [DATA_W-1:0] x);
        return {{(SW - DATA_W){x[DATA_W-1]}}, x};
    endfunction

    for (genvar j = 0; j < 4; j++) begin : g_col
        logic signed [SW-1:0] acc;
        logic signed [SW-1:0] shr;
        logic [DATA_W-1:0]    y;

        // Products and sum stay at full width; the only loss is the final shift.
        always_comb begin
            acc = '0;
            for (int k = 0; k < 4; k++) begin
                acc = acc + sext(row_i[k]) * sext(mat_i[k][j]);
            end
            shr = acc >>> FRAC_W;
            if (shr > MAX_V)      y = MAX_V[DATA_W-1:0];
            else if (shr < MIN_V) y = MIN_V[DATA_W-1:0];
            else                  y = shr[DATA_W-1:0];
        end

        assign res_o[j] = y;
    end
endmodule

// File: rtl/ff_ga_stack.sv
// Geometry accelerator top: command FSM, operand/composite/result registers and the
// composite-matrix stack. A single row MAC is reused across the four MUL cycles.
module ff_ga_stack
    import ff_ga_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int FRAC_W      = 16,
    parameter int STACK_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    ff_ga_stack_if.slave bus
);
    localparam int LW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef `FF_GA_MAT4_T(DATA_W) mat_t;
    typedef logic [0:3][DATA_W-1:0] row_t;

    function automatic mat_t identity();
        mat_t m;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                m[r][c] = DATA_W'(ident_word(r, c, FRAC_W));
            end
        end
        return m;
    endfunction

    localparam mat_t ID_M = identity();

    state_e        state_q, state_d;
    cmd_e          cmd_q, cmd_d;
    logic [1:0]    cnt_q, cnt_d;
    mat_t          op_q, op_d;
    mat_t          comp_q, comp_d;
    mat_t          res_q, res_d;
    row_t          dout_q, dout_d;
    row_t          mac_row;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    mat_t          stack_q [STACK_DEPTH];
    logic          stk_we;
    logic [IW-1:0] wr_idx, rd_idx;
    logic          addr_ok;
    cmd_e          addr_cmd;

    assign addr_ok  = (bus.addr < 32'd6);
    assign addr_cmd = cmd_e'(bus.addr[2:0]);
    assign wr_idx   = lvl_q[IW-1:0];
    assign rd_idx   = IW'(lvl_q - LW'(1));

    ff_ga_row_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .row_i (comp_q[cnt_q]),
        .mat_i (op_q),
        .res_o (mac_row)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (addr_ok) begin
                    case (addr_cmd)
                        MATRIX, VRT: state_d = LOAD;
                        RSLT:        state_d = READ;
                        default:     state_d = STK;
                    endcase
                end
            end
            LOAD:      if (cnt_q == 2'd3) state_d = MUL;
            MUL, READ: if (cnt_q == 2'd3) state_d = IDLE;
            STK:       state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.rdy = (state_q == IDLE);
    end

    assign bus.data_out  = dout_q;
    assign bus.err_ovf   = ovf_q;
    assign bus.err_udf   = udf_q;
    assign bus.stack_lvl = lvl_q;

    // ---------------- datapath next state ----------------
    always_comb begin
        cmd_d  = cmd_q;
        cnt_d  = 2'd0;
        op_d   = op_q;
        comp_d = comp_q;
        res_d  = res_q;
        dout_d = dout_q;
        lvl_d  = lvl_q;
        ovf_d  = ovf_q;
        udf_d  = udf_q;
        stk_we = 1'b0;
        case (state_q)
            IDLE: if (addr_ok) cmd_d = addr_cmd;
            LOAD: begin
                op_d[cnt_q] = bus.data_in;
                cnt_d       = cnt_q + 2'd1;
            end
            MUL: begin
                // Row i of C feeds only row i of R, so C can be overwritten in place.
                res_d[cnt_q] = mac_row;
                if (cmd_q == MATRIX) comp_d[cnt_q] = mac_row;
                cnt_d = cnt_q + 2'd1;
            end
            READ: begin
                for (int r = 0; r < 4; r++) dout_d[r] = res_q[r][cnt_q];
                cnt_d = cnt_q + 2'd1;
            end
            STK: begin
                case (cmd_q)
                    IDENT: begin
                        comp_d = ID_M;
                        res_d  = ID_M;
                    end
                    PUSH: begin
                        if (lvl_q < LW'(STACK_DEPTH)) begin
                            stk_we = 1'b1;
                            lvl_d  = lvl_q + LW'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    POP: begin
                        if (lvl_q != '0) begin
                            lvl_d  = lvl_q - LW'(1);
                            comp_d = stack_q[rd_idx];
                            res_d  = stack_q[rd_idx];
                        end else begin
                            udf_d = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q  <= MATRIX;
            cnt_q  <= 2'd0;
            op_q   <= '0;
            comp_q <= ID_M;
            res_q  <= ID_M;
            dout_q <= '0;
            lvl_q  <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            cmd_q  <= cmd_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            comp_q <= comp_d;
            res_q  <= res_d;
            dout_q <= dout_d;
            lvl_q  <= lvl_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    // Stack contents need no reset: occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (!rst && stk_we) stack_q[wr_idx] <= comp_q;
    end
endmodule

// File: tb/tb_ff_ga_stack.sv
// Directed bench for ff_ga_stack at default parameters (Q16.16, depth 8).
module tb_ff_ga_stack;
    import ff_ga_pkg::*;

    typedef logic [0:3][0:3][31:0] m_t;
    localparam logic [31:0] ONE = 32'h0001_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    ff_ga_stack_if #(.DATA_W(32), .STACK_DEPTH(8)) bus ();

    ff_ga_stack #(.DATA_W(32), .FRAC_W(16), .STACK_DEPTH(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_mat(input string tag, input m_t got, input m_t exp);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                chk($sformatf("%s[%0d][%0d]", tag, r, c), 64'(got[r][c]), 64'(exp[r][c]));
    endtask

    function automatic m_t diag(input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] c, input logic [31:0] d);
        m_t m;
        m = '0;
        m[0][0] = a; m[1][1] = b; m[2][2] = c; m[3][3] = d;
        return m;
    endfunction

    task automatic do_rst();
        rst         = 1'b1;
        bus.addr    = 32'd7;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits (bounded) for rdy, presents the command for one edge, returns after E0.
    task automatic issue(input int unsigned cmd);
        int n;
        n = 0;
        while (bus.rdy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rdy_wait", 64'(bus.rdy), 64'd1);
        bus.addr = cmd;
        @(negedge clk);
        bus.addr = 32'd7;
        chk("rdy_drop", 64'(bus.rdy), 64'd0);
    endtask

    task automatic send_mat(input m_t m, input int unsigned cmd);
        issue(cmd);
        for (int r = 0; r < 4; r++) begin
            bus.data_in = m[r];
            @(negedge clk);
        end
        bus.data_in = '0;
        repeat (4) @(negedge clk);
        chk("mul_done", 64'(bus.rdy), 64'd1);
    endtask

    task automatic read(output m_t res);
        issue(RSLT);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            for (int r = 0; r < 4; r++) res[r][j] = bus.data_out[r];
        end
    endtask

    task automatic stk(input int unsigned cmd);
        issue(cmd);
        @(negedge clk);
    endtask

    initial begin
        m_t got, id, o, t, e_ot, v, e_v, s, a;

        bus.addr    = 32'd7;
        bus.data_in = '0;
        id = diag(ONE, ONE, ONE, ONE);
        @(negedge clk);
        do_rst();

        // 1. reset state and identity readback
        chk("rst_rdy", 64'(bus.rdy), 64'd1);
        chk("rst_lvl", 64'(bus.stack_lvl), 64'd0);
        chk("rst_ovf", 64'(bus.err_ovf), 64'd0);
        chk("rst_udf", 64'(bus.err_udf), 64'd0);
        chk("rst_dout", 64'(bus.data_out == '0), 64'd1);
        read(got);
        chk_mat("t1_id", got, id);

        // 2. ortho then translate(1,2,3)
        o = diag(ONE, ONE, 32'hffff_fffa, ONE);
        o[0][3] = 32'h012c_0000;
        o[1][3] = 32'h012c_0000;
        t = id;
        t[0][3] = 32'h0001_0000;
        t[1][3] = 32'h0002_0000;
        t[2][3] = 32'h0003_0000;
        send_mat(o, MATRIX);
        send_mat(t, MATRIX);
        read(got);
        e_ot = o;
        e_ot[0][3] = 32'h012d_0000;
        e_ot[1][3] = 32'h012e_0000;
        e_ot[2][3] = 32'hffff_ffee;
        chk_mat("t2_ot", got, e_ot);

        // 3. vertex transform leaves the composite alone
        v = '0;
        v[0][0] = ONE; v[1][0] = 32'h0002_0000; v[2][0] = 32'h0003_0000; v[3][0] = ONE;
        send_mat(v, VRT);
        read(got);
        e_v = '0;
        e_v[0][0] = 32'h012e_0000; e_v[1][0] = 32'h0130_0000;
        e_v[2][0] = 32'hffff_ffdc; e_v[3][0] = ONE;
        chk_mat("t3_vrt", got, e_v);
        send_mat(id, MATRIX);
        read(got);
        chk_mat("t3_comp", got, e_ot);

        // 4. push / scale / pop restores, then overflow and underflow
        chk("t4_lvl0", 64'(bus.stack_lvl), 64'd0);
        stk(PUSH);
        chk("t4_lvl1", 64'(bus.stack_lvl), 64'd1);
        s = diag(32'h0002_0000, 32'h0002_0000, 32'h0002_0000, ONE);
        send_mat(s, MATRIX);
        stk(POP);
        chk("t4_lvl_pop", 64'(bus.stack_lvl), 64'd0);
        read(got);
        chk_mat("t4_pop", got, e_ot);
        for (int i = 0; i < 8; i++) stk(PUSH);
        chk("t4_lvl_full", 64'(bus.stack_lvl), 64'd8);
        chk("t4_ovf_clr", 64'(bus.err_ovf), 64'd0);
        stk(PUSH);
        chk("t4_ovf", 64'(bus.err_ovf), 64'd1);
        chk("t4_lvl_hold", 64'(bus.stack_lvl), 64'd8);
        stk(IDENT);
        stk(POP);
        chk("t4_ovf_sticky", 64'(bus.err_ovf), 64'd1);
        chk("t4_lvl7", 64'(bus.stack_lvl), 64'd7);
        read(got);
        chk_mat("t4_deep_pop", got, e_ot);
        do_rst();
        chk("t4_ovf_rst", 64'(bus.err_ovf), 64'd0);
        stk(POP);
        chk("t4_udf", 64'(bus.err_udf), 64'd1);
        chk("t4_lvl_empty", 64'(bus.stack_lvl), 64'd0);
        read(got);
        chk_mat("t4_udf_id", got, id);

        // 5. saturation both directions
        a = diag(32'h7fff_0000, 32'h7fff_0000, 32'h7fff_0000, 32'h7fff_0000);
        stk(IDENT);
        send_mat(a, MATRIX);
        send_mat(a, MATRIX);
        read(got);
        chk_mat("t5_satp", got, diag(32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff));
        stk(IDENT);
        read(got);
        chk_mat("t5_ident", got, id);
        send_mat(diag(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000), MATRIX);
        send_mat(a, MATRIX);
        read(got);
        chk_mat("t5_satn", got, diag(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000));

        // 6. reset mid-LOAD, then addr toggling during a command
        stk(PUSH);
        chk("t6_lvl1", 64'(bus.stack_lvl), 64'd1);
        issue(MATRIX);
        bus.data_in = s[0];
        @(negedge clk);
        bus.data_in = s[1];
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.data_in = '0;
        chk("t6_rdy", 64'(bus.rdy), 64'd1);
        chk("t6_dout", 64'(bus.data_out == '0), 64'd1);
        chk("t6_lvl", 64'(bus.stack_lvl), 64'd0);
        read(got);
        chk_mat("t6_id", got, id);

        issue(MATRIX);
        for (int r = 0; r < 4; r++) begin
            bus.data_in = s[r];
            bus.addr    = (r % 2 == 0) ? 32'd0 : 32'd2;
            @(negedge clk);
            chk("t6_load_busy", 64'(bus.rdy), 64'd0);
        end
        bus.data_in = '0;
        for (int i = 0; i < 4; i++) begin
            bus.addr = (i == 3) ? 32'd7 : 32'd0;
            @(negedge clk);
            chk("t6_mul_rdy", 64'(bus.rdy), (i == 3) ? 64'd1 : 64'd0);
        end
        read(got);
        chk_mat("t6_toggle", got, s);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
